// File: rtl/grant_merge.sv
// rtl/grant_merge.sv - 2:1 grant-ordered packet merge into a DEPTH-entry output FIFO
// One arbiter grant token admits exactly one packet from the granted requester.
module grant_merge #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     grant_valid,
  input  logic                     grant_sel,
  output logic                     grant_ready,
  input  logic                     in0_valid,
  input  logic [WIDTH-1:0]         in0_data,
  output logic                     in0_ready,
  input  logic                     in1_valid,
  input  logic [WIDTH-1:0]         in1_data,
  output logic                     in1_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         pkt_cnt0,
  output logic [CNT_W-1:0]         pkt_cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_push_data;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;

  // Readies depend only on registered state and occupancy, never on the valids.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    grant_ready = 1'b0;
    in0_ready   = 1'b0;
    in1_ready   = 1'b0;
    w_push      = 1'b0;
    w_push_data = r_sel ? in1_data : in0_data;
    case (r_state)
      S_IDLE: begin
        grant_ready = 1'b1;
        if (grant_valid) begin
          w_state_nxt = S_GRANTED;
          w_sel_nxt   = grant_sel;
        end
      end
      S_GRANTED: begin
        in0_ready = !r_sel && !w_full;
        in1_ready = r_sel && !w_full;
        w_push    = r_sel ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
        if (w_push) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_push) begin
      if (r_sel) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end else begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
    end
  end

  assign out_valid  = !w_empty;
  assign out_data   = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign pkt_cnt0   = r_cnt0;
  assign pkt_cnt1   = r_cnt1;

endmodule

// File: tb/tb_grant_merge.sv
// tb/tb_grant_merge.sv - scoreboard bench for grant_merge
// Stimulus pushes expected packets; a negedge monitor pops and compares on each output pop.
module tb_grant_merge;

  localparam int WIDTH = 33;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             grant_valid = 1'b0;
  logic             grant_sel = 1'b0;
  logic             grant_ready;
  logic             in0_valid = 1'b0;
  logic [WIDTH-1:0] in0_data = '0;
  logic             in0_ready;
  logic             in1_valid = 1'b0;
  logic [WIDTH-1:0] in1_data = '0;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       fifo_count;
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;

  grant_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .grant_valid(grant_valid), .grant_sel(grant_sel), .grant_ready(grant_ready),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_count(fifo_count), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] exp_q [$];
  logic [CNT_W-1:0] exp_cnt0 = '0;
  logic [CNT_W-1:0] exp_cnt1 = '0;
  logic             cur_sel = 1'b0;
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               t4_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor plus grant-exclusivity check on ready outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", {31'd0, out_data}, 64'h0);
        end else begin
          chk("out_data", {31'd0, out_data}, {31'd0, exp_q.pop_front()});
        end
      end
      if (in0_ready || in1_ready) begin
        chk("ready_excl", {62'd0, grant_ready, in0_ready & in1_ready}, 64'd0);
        chk("ready_sel", {63'd0, in1_ready}, {63'd0, cur_sel});
      end
    end
  end

  task automatic send(input logic s, input logic [WIDTH-1:0] d, input bit decoy);
    int n;
    bit got;
    n = 0;
    while (!grant_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!grant_ready) begin
      chk("grant_wait_timeout", 64'd0, 64'd1);
      return;
    end
    cur_sel     = s;
    grant_valid = 1'b1;
    grant_sel   = s;
    if (s) begin
      in1_valid = 1'b1; in1_data = d;
      in0_valid = decoy; in0_data = ~d;
    end else begin
      in0_valid = 1'b1; in0_data = d;
      in1_valid = decoy; in1_data = ~d;
    end
    @(posedge clk);
    #1;
    grant_valid = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = s ? in1_ready : in0_ready;
      n++;
    end
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(d);
      if (s) exp_cnt1 = exp_cnt1 + 1'b1;
      else   exp_cnt0 = exp_cnt0 + 1'b1;
      #1;
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset state
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_grant_ready", {63'd0, grant_ready}, 64'd1);
    chk("rst_in_ready", {62'd0, in0_ready, in1_ready}, 64'd0);
    chk("rst_fifo_count", {61'd0, fifo_count}, 64'd0);
    chk("rst_out_data", {31'd0, out_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2. single packet latency
    out_ready   = 1'b1;
    cur_sel     = 1'b0;
    grant_valid = 1'b1;
    grant_sel   = 1'b0;
    in0_valid   = 1'b1;
    in0_data    = 33'h1_2345_6789;
    @(posedge clk);
    #1;
    grant_valid = 1'b0;
    chk("t2_in0_ready", {63'd0, in0_ready}, 64'd1);
    chk("t2_grant_ready", {63'd0, grant_ready}, 64'd0);
    @(posedge clk);
    exp_q.push_back(33'h1_2345_6789);
    exp_cnt0 = exp_cnt0 + 1'b1;
    #1;
    in0_valid = 1'b0;
    chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t2_out_data", {31'd0, out_data}, {31'd0, 33'h1_2345_6789});
    chk("t2_pkt_cnt0", 64'(pkt_cnt0), 64'd1);
    drain();

    // 3. alternating grants, both inputs valid
    send(1'b0, 33'h0_A0A0_0000, 1'b1);
    send(1'b1, 33'h1_B0B0_0000, 1'b1);
    send(1'b0, 33'h0_A1A1_0001, 1'b1);
    send(1'b1, 33'h1_B1B1_0001, 1'b1);
    drain();
    chk("t3_pkt_cnt0", 64'(pkt_cnt0), 64'(exp_cnt0));
    chk("t3_pkt_cnt1", 64'(pkt_cnt1), 64'd2);

    // 4. full FIFO blocks the fifth packet
    out_ready = 1'b0;
    t4_done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send(logic'(i & 1), 33'h0_4000_0000 + 33'(i), 1'b0);
        end
        t4_done = 1'b1;
      end
    join_none
    repeat (14) @(posedge clk);
    #1;
    chk("t4_fifo_full", {61'd0, fifo_count}, 64'd4);
    chk("t4_in0_ready_blocked", {63'd0, in0_ready}, 64'd0);
    chk("t4_grant_ready_held", {63'd0, grant_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_fifo_after_pop", {61'd0, fifo_count}, 64'd3);
    chk("t4_in0_ready_after_pop", {63'd0, in0_ready}, 64'd1);
    for (int n = 0; n < 50 && !t4_done; n++) @(posedge clk);
    chk("t4_done", {63'd0, t4_done}, 64'd1);
    drain();

    // 5. simultaneous push and pop at count 2, write pointer wraps
    out_ready = 1'b0;
    send(1'b0, 33'h0_C000_0000, 1'b0);
    send(1'b1, 33'h1_C000_0001, 1'b0);
    chk("t5_count_2", {61'd0, fifo_count}, 64'd2);
    cur_sel     = 1'b0;
    grant_valid = 1'b1;
    grant_sel   = 1'b0;
    in0_valid   = 1'b1;
    in0_data    = 33'h0_C000_0002;
    @(posedge clk);
    #1;
    grant_valid = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk);
    exp_q.push_back(33'h0_C000_0002);
    exp_cnt0 = exp_cnt0 + 1'b1;
    #1;
    in0_valid = 1'b0;
    out_ready = 1'b0;
    chk("t5_count_stays_2", {61'd0, fifo_count}, 64'd2);
    drain();
    chk("t5_pkt_cnt0", 64'(pkt_cnt0), 64'(exp_cnt0));

    // 6. async reset during GRANTED with two packets queued
    out_ready = 1'b0;
    send(1'b0, 33'h0_DEAD_0000, 1'b0);
    send(1'b1, 33'h1_DEAD_0001, 1'b0);
    cur_sel     = 1'b1;
    grant_valid = 1'b1;
    grant_sel   = 1'b1;
    @(posedge clk);
    #1;
    grant_valid = 1'b0;
    chk("t6_in1_ready_granted", {63'd0, in1_ready}, 64'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    #1;
    chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_grant_ready", {63'd0, grant_ready}, 64'd1);
    chk("t6_in1_ready", {63'd0, in1_ready}, 64'd0);
    chk("t6_fifo_count", {61'd0, fifo_count}, 64'd0);
    chk("t6_cnts", {56'd0, pkt_cnt0, pkt_cnt1}, 64'd0);
    chk("t6_out_data", {31'd0, out_data}, 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(1'b1, 33'h1_0000_0100 + 33'(i), 1'b0);
    end
    chk("t6_pkt_cnt1_15", 64'(pkt_cnt1), 64'd15);
    send(1'b1, 33'h1_0000_01FF, 1'b0);
    chk("t6_pkt_cnt1_wrap", 64'(pkt_cnt1), 64'd0);
    chk("t6_pkt_cnt0", 64'(pkt_cnt0), 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
